// File: rtl/mtm_alu_tx_scheduler.sv
// mtm_alu_tx_scheduler
//
// Purpose: collects result and error responses from the ALU core into a small
// FIFO and streams each one to the byte serializer as a frame. A result frame
// is the four bytes of C (MSB first, tx_cmd=0) followed by its control byte
// (tx_cmd=1). An error frame is the control byte alone (tx_cmd=1). Frames are
// sent whole, in queue order, with one idle cycle between consecutive frames.
//
// Ports:
//   clk        single clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   res_valid  result request; res_c = result word, res_ctl = control byte
//   res_ready  result request is accepted this cycle when res_valid=1
//   err_valid  error request; err_ctl = control byte
//   err_ready  error request is accepted this cycle when err_valid=1
//   tx_valid   byte offered to serializer; tx_data = byte, tx_cmd = 1 for control
//   tx_ready   serializer takes the byte when tx_valid & tx_ready
//   busy       FSM not idle or queue not empty
//
// Parameter QDEPTH: queue depth in entries, power of two in 2..8.
//
// Build option: define MTM_ALU_TX_RR_EN for round-robin arbitration between
// simultaneous result and error requests (the last granted side loses, error
// wins first after reset). Without it, errors always win.

module mtm_alu_tx_scheduler #(
    parameter int QDEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        res_valid,
    input  logic [31:0] res_c,
    input  logic [7:0]  res_ctl,
    output logic        res_ready,
    input  logic        err_valid,
    input  logic [7:0]  err_ctl,
    output logic        err_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_cmd,
    input  logic        tx_ready,
    output logic        busy
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CMD  = 2'd2
    } state_t;

    // Response queue storage (data only, no reset needed).
    logic        q_kind [QDEPTH];
    logic [31:0] q_c    [QDEPTH];
    logic [7:0]  q_ctl  [QDEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    state_t      state;
    logic [1:0]  idx;
    logic [31:0] frame_c;
    logic [7:0]  frame_ctl;

    logic full;
    logic empty;
    logic accept_ok;
    logic push_err;
    logic push_res;
    logic push;
    logic pop;
    logic handshake;

    function automatic logic [7:0] c_byte(input logic [31:0] c, input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = c[31:24];
            2'd1:    b = c[23:16];
            2'd2:    b = c[15:8];
            default: b = c[7:0];
        endcase
        return b;
    endfunction

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Ready is forced low while reset is asserted so nothing is accepted
    // until the first rising edge after release.
    assign accept_ok = rst_n & ~full;

`ifdef MTM_ALU_TX_RR_EN
    logic err_first;

    assign err_ready = accept_ok & (~res_valid | err_first);
    assign res_ready = accept_ok & (~err_valid | ~err_first);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_first <= 1'b1;
        end else if (push_err) begin
            err_first <= 1'b0;
        end else if (push_res) begin
            err_first <= 1'b1;
        end
    end
`else
    assign err_ready = accept_ok;
    assign res_ready = accept_ok & ~err_valid;
`endif

    // The two grants are mutually exclusive by construction of the ready terms.
    assign push_err  = err_valid & err_ready;
    assign push_res  = res_valid & res_ready;
    assign push      = push_err | push_res;
    assign pop       = (state == IDLE) & ~empty;
    assign handshake = tx_valid & tx_ready;
    assign busy      = (state != IDLE) | ~empty;

    always_ff @(posedge clk) begin
        if (push) begin
            q_kind[wr_ptr] <= push_err;
            q_c[wr_ptr]    <= push_err ? 32'd0 : res_c;
            q_ctl[wr_ptr]  <= push_err ? err_ctl : res_ctl;
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            frame_c   <= q_c[rd_ptr];
            frame_ctl <= q_ctl[rd_ptr];
        end
    end

    // Pointers wrap naturally because QDEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame FSM with registered outputs. The first byte is loaded straight
    // from the queue head on the pop edge, later bytes from the frame register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= 2'd0;
            tx_valid <= 1'b0;
            tx_cmd   <= 1'b0;
            tx_data  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        idx      <= 2'd0;
                        tx_valid <= 1'b1;
                        if (!q_kind[rd_ptr]) begin
                            state   <= DATA;
                            tx_cmd  <= 1'b0;
                            tx_data <= c_byte(q_c[rd_ptr], 2'd0);
                        end else begin
                            state   <= CMD;
                            tx_cmd  <= 1'b1;
                            tx_data <= q_ctl[rd_ptr];
                        end
                    end
                end
                DATA: begin
                    if (handshake) begin
                        if (idx == 2'd3) begin
                            state   <= CMD;
                            tx_cmd  <= 1'b1;
                            tx_data <= frame_ctl;
                        end else begin
                            idx     <= idx + 2'd1;
                            tx_data <= c_byte(frame_c, idx + 2'd1);
                        end
                    end
                end
                CMD: begin
                    if (handshake) begin
                        state    <= IDLE;
                        tx_valid <= 1'b0;
                        tx_cmd   <= 1'b0;
                        tx_data  <= 8'd0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    tx_cmd   <= 1'b0;
                    tx_data  <= 8'd0;
                end
            endcase
        end
    end

endmodule
